alu_muldiv: RTL and testbench

- Parametrised successor to the CPU's single-cycle ALU. Keeps the combinational datapath ops (result/zero, now with overflow and extra ops).
- Adds an iterative multi-cycle multiply/divide unit with architectural HI/LO registers and a start/busy/done handshake.
- Sits in the EX stage. Control holds the pipeline while busy=1 and reads hi/lo for MFHI/MFLO.

---
 rtl/alu_muldiv.sv | 266 ++++++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// EX-stage ALU: combinational single-cycle ops plus an iterative signed/unsigned
// multiply/divide unit writing architectural HI/LO with a start/busy/done handshake.
module alu_muldiv #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   input  logic             start,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_SLTU  = 4'b0100;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_SLL   = 4'b1000;
   localparam logic [3:0] OP_SRL   = 4'b1001;
   localparam logic [3:0] OP_MULT  = 4'b1010;
   localparam logic [3:0] OP_MULTU = 4'b1011;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_SRA   = 4'b1101;
   localparam logic [3:0] OP_DIV   = 4'b1110;
   localparam logic [3:0] OP_DIVU  = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   logic [WIDTH-1:0] sum_s, diff_s, result_s;
   logic [SHW-1:0]   shamt_s;
   logic             overflow_s;

   // Single-cycle datapath: result, zero and overflow.
   always_comb begin
      sum_s      = a + b;
      diff_s     = a - b;
      shamt_s    = a[SHW-1:0];
      result_s   = {WIDTH{1'b0}};
      overflow_s = 1'b0;
      case (alu_control)
         OP_ADD: begin
            result_s   = sum_s;
            overflow_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            result_s   = diff_s;
            overflow_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  result_s = a & b;
         OP_OR:   result_s = a | b;
         OP_XOR:  result_s = a ^ b;
         OP_NOR:  result_s = ~(a | b);
         OP_SLT:  result_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: result_s = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLL:  result_s = b << shamt_s;
         OP_SRL:  result_s = b >> shamt_s;
         OP_SRA:  result_s = $signed(b) >>> shamt_s;
         default: result_s = {WIDTH{1'b0}};
      endcase
   end

   assign result   = result_s;
   assign zero     = (result_s == {WIDTH{1'b0}});
   assign overflow = overflow_s;

   state_t           state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;
   logic             is_div_q, is_div_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             md_s, md_div_s, md_sgn_s, launch_s;
   logic [WIDTH-1:0] a_mag_s, b_mag_s;

   // Decode a mul/div launch and form operand magnitudes for signed ops.
   always_comb begin
      md_s     = 1'b1;
      md_div_s = 1'b0;
      md_sgn_s = 1'b0;
      case (alu_control)
         OP_MULT:  md_sgn_s = 1'b1;
         OP_MULTU: md_sgn_s = 1'b0;
         OP_DIV: begin
            md_div_s = 1'b1;
            md_sgn_s = 1'b1;
         end
         OP_DIVU:  md_div_s = 1'b1;
         default:  md_s     = 1'b0;
      endcase
      if (md_sgn_s && a[WIDTH-1]) begin
         a_mag_s = {WIDTH{1'b0}} - a;
      end else begin
         a_mag_s = a;
      end
      if (md_sgn_s && b[WIDTH-1]) begin
         b_mag_s = {WIDTH{1'b0}} - b;
      end else begin
         b_mag_s = b;
      end
      launch_s = start && !busy_q && md_s;
   end

   logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
   logic [WIDTH-1:0]   step_hi_s, step_lo_s;
   logic [2*WIDTH-1:0] prod_s, prod_fin_s;
   logic [WIDTH-1:0]   quo_fin_s, rem_fin_s;

   // One iteration: shift-add for multiply, restoring step for divide; plus final sign fix.
   always_comb begin
      mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_diff_s  = div_shift_s - {1'b0, opnd_q};
      if (is_div_q) begin
         if (!div_diff_s[WIDTH]) begin
            step_hi_s = div_diff_s[WIDTH-1:0];
            step_lo_s = {acc_lo_q[WIDTH-2:0], 1'b1};
         end else begin
            step_hi_s = div_shift_s[WIDTH-1:0];
            step_lo_s = {acc_lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_hi_s = mul_sum_s[WIDTH:1];
         step_lo_s = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
      end
      prod_s     = {step_hi_s, step_lo_s};
      prod_fin_s = neg_res_q ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
      quo_fin_s  = neg_res_q ? ({WIDTH{1'b0}} - step_lo_s) : step_lo_s;
      rem_fin_s  = neg_rem_q ? ({WIDTH{1'b0}} - step_hi_s) : step_hi_s;
   end

   // Next-state logic for the mul/div sequencer and HI/LO.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      dbz_d     = 1'b0;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      opnd_d    = opnd_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         S_IDLE: state_d = S_IDLE;
         S_RUN: begin
            acc_hi_d = step_hi_s;
            acc_lo_d = step_lo_s;
            if (cnt_q == {SHW{1'b0}}) begin
               if (is_div_q) begin
                  hi_d = rem_fin_s;
                  lo_d = quo_fin_s;
               end else begin
                  hi_d = prod_fin_s[2*WIDTH-1:WIDTH];
                  lo_d = prod_fin_s[WIDTH-1:0];
               end
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_FIN;
            end else begin
               cnt_d = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
            end
         end
         S_FIN: begin
            // busy still set here means a divide-by-zero is waiting for its write.
            if (busy_q) begin
               hi_d   = acc_lo_q;
               lo_d   = {WIDTH{1'b1}};
               busy_d = 1'b0;
               done_d = 1'b1;
               dbz_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
      if (launch_s) begin
         is_div_d  = md_div_s;
         neg_res_d = md_sgn_s && (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_rem_d = md_sgn_s && a[WIDTH-1];
         busy_d    = 1'b1;
         cnt_d     = SHW'(WIDTH - 1);
         acc_hi_d  = {WIDTH{1'b0}};
         opnd_d    = b_mag_s;
         if (md_div_s && (b == {WIDTH{1'b0}})) begin
            acc_lo_d = a;
            state_d  = S_FIN;
         end else begin
            acc_lo_d = a_mag_s;
            state_d  = S_RUN;
         end
      end else begin
         is_div_d = is_div_d;
      end
   end

   // Sequencer registers with asynchronous reset discarding any in-flight op.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= {SHW{1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         opnd_q    <= {WIDTH{1'b0}};
         acc_hi_q  <= {WIDTH{1'b0}};
         acc_lo_q  <= {WIDTH{1'b0}};
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         opnd_q    <= opnd_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv (WIDTH=32) with hand-computed expectations.
module tb_alu_muldiv;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic [3:0]  alu_control = 4'b0000;
   logic        start = 1'b0;
   logic [31:0] result, hi, lo;
   logic        zero, overflow, busy, done, div_by_zero;

   int n_vec = 0;
   int n_err = 0;

   alu_muldiv #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .alu_control(alu_control),
      .start(start), .result(result), .zero(zero), .overflow(overflow),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic comb(input string tag, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] exp_r, input logic exp_ovf);
      alu_control = op;
      a = av;
      b = bv;
      #1;
      chk({tag, ".result"}, {32'd0, result}, {32'd0, exp_r});
      chk({tag, ".zero"}, {63'd0, zero}, {63'd0, (exp_r == 32'd0)});
      chk({tag, ".ovf"}, {63'd0, overflow}, {63'd0, exp_ovf});
   endtask

   // Returns #1 after the launch edge with start dropped.
   task automatic launch(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
      alu_control = op;
      a = av;
      b = bv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges after launch until done; pokes a stray start at cycle 'poke' if nonzero.
   task automatic wait_done(input int poke, output int lat, output int busy_cnt, output logic dbz);
      lat = -1;
      dbz = 1'b0;
      busy_cnt = busy ? 1 : 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            dbz = div_by_zero;
            break;
         end
         if (busy) busy_cnt++;
         if (poke != 0 && i == poke) begin
            a = 32'd9;
            b = 32'd9;
            start = 1'b1;
         end
         if (poke != 0 && i == poke + 1) start = 1'b0;
      end
   endtask

   task automatic md_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int lat, bc;
      logic dbz;
      launch(op, av, bv);
      wait_done(0, lat, bc, dbz);
      chk({tag, ".lat"}, 64'(lat), 64'd32);
      chk({tag, ".hilo"}, {hi, lo}, {exp_hi, exp_lo});
      chk({tag, ".dbz"}, {63'd0, dbz}, 64'd0);
   endtask

   initial begin
      int lat, bc, seen;
      logic dbz;

      #12;
      chk("rst.hilo", {hi, lo}, 64'd0);
      chk("rst.ctl", {61'd0, busy, done, div_by_zero}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      comb("add", 4'b0010, 32'd7, 32'hFFFFFFFD, 32'd4, 1'b0);
      comb("sub0", 4'b0110, 32'd5, 32'd5, 32'd0, 1'b0);
      comb("addovf", 4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1);
      comb("subovf", 4'b0110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1);
      comb("slt", 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
      comb("sltu", 4'b0100, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
      comb("sra", 4'b1101, 32'd4, 32'h80000000, 32'hF8000000, 1'b0);
      comb("srl", 4'b1001, 32'd4, 32'h80000000, 32'h08000000, 1'b0);
      comb("sll", 4'b1000, 32'd31, 32'd1, 32'h80000000, 1'b0);
      comb("and", 4'b0000, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b0);
      comb("or", 4'b0001, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0);
      comb("xor", 4'b0011, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0);
      comb("nor", 4'b1100, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0);
      comb("mulcode", 4'b1010, 32'd3, 32'd4, 32'd0, 1'b0);

      // Signed multiply with explicit latency and busy-width checks.
      launch(4'b1010, 32'hFFFFFFFD, 32'd5);
      wait_done(0, lat, bc, dbz);
      chk("mult.lat", 64'(lat), 64'd32);
      chk("mult.busy", 64'(bc), 64'd32);
      chk("mult.busy_at_done", {63'd0, busy}, 64'd0);
      chk("mult.hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFF1});
      @(posedge clk);
      #1;
      chk("mult.done_pulse", {63'd0, done}, 64'd0);

      md_op("multu", 4'b1011, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE);
      md_op("mult_nn", 4'b1010, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0, 32'd6);
      md_op("div", 4'b1110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      md_op("divu", 4'b1111, 32'd100, 32'd7, 32'd2, 32'd14);
      md_op("divmin", 4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

      launch(4'b1111, 32'd9, 32'd0);
      wait_done(0, lat, bc, dbz);
      chk("dbz.lat", 64'(lat), 64'd1);
      chk("dbz.flag", {63'd0, dbz}, 64'd1);
      chk("dbz.hilo", {hi, lo}, {32'd9, 32'hFFFFFFFF});
      @(posedge clk);
      #1;
      chk("dbz.clear", {62'd0, done, div_by_zero}, 64'd0);

      // Stray start mid-multiply must be ignored.
      launch(4'b1010, 32'd6, 32'd7);
      wait_done(10, lat, bc, dbz);
      chk("ign.lat", 64'(lat), 64'd32);
      chk("ign.hilo", {hi, lo}, {32'd0, 32'd42});
      @(posedge clk);
      #1;
      chk("ign.idle", {62'd0, busy, done}, 64'd0);

      // Back-to-back: start held in the done cycle launches the next op.
      launch(4'b1011, 32'd3, 32'd5);
      wait_done(0, lat, bc, dbz);
      chk("b2b1.hilo", {hi, lo}, {32'd0, 32'd15});
      launch(4'b1111, 32'd50, 32'd8);
      chk("b2b.relaunch", {62'd0, busy, done}, 64'd2);
      wait_done(0, lat, bc, dbz);
      chk("b2b2.lat", 64'(lat), 64'd32);
      chk("b2b2.hilo", {hi, lo}, {32'd2, 32'd6});

      // Asynchronous reset in the middle of a divide.
      launch(4'b1110, 32'd1000, 32'd3);
      repeat (15) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("rmid.ctl", {62'd0, busy, done}, 64'd0);
      chk("rmid.hilo", {hi, lo}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen++;
      end
      chk("rmid.nodone", 64'(seen), 64'd0);
      chk("rmid.hilo_hold", {hi, lo}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
